// File: rtl/tmds_word_align.sv
// tmds_word_align: TMDS word-boundary acquisition and 10b->8b decode for one channel.
//
// Watches the deserialized word stream for a run of TOKEN_RUN consecutive control tokens.
// While no run is found, it requests one bitslip per SEARCH_WIN cycles. Each bitslip is
// followed by SLIP_WAIT settle cycles. Once a run is seen, the block reports locked. Lock is
// dropped, without a slip, if no further run appears within LOSS_WIN cycles. Every word is
// also decoded in a 2-stage pipeline into pixel data or a control code.
//
// Ports:
//   pclk        in   pixel clock
//   reset_n     in   asynchronous active-low reset
//   din[9:0]    in   deserialized word, din[0] is the first bit on the wire
//   data[7:0]   out  decoded pixel byte (valid when de=1)
//   ctl[1:0]    out  decoded control code {C1,C0} (valid when de=0)
//   de          out  1 = pixel data, 0 = control period
//   locked      out  word alignment established
//   bitslip     out  one-cycle slip request to the deserializer
//   slip_count  out  current slip position 0..9

module tmds_word_align #(
    parameter int unsigned TOKEN_RUN  = 8,
    parameter int unsigned SEARCH_WIN = 2048,
    parameter int unsigned SLIP_WAIT  = 16,
    parameter int unsigned LOSS_WIN   = 1048576
) (
    input  logic       pclk,
    input  logic       reset_n,
    input  logic [9:0] din,
    output logic [7:0] data,
    output logic [1:0] ctl,
    output logic       de,
    output logic       locked,
    output logic       bitslip,
    output logic [3:0] slip_count
);

    localparam logic [9:0]  TOK_00   = 10'h354;
    localparam logic [9:0]  TOK_01   = 10'h0AB;
    localparam logic [9:0]  TOK_10   = 10'h154;
    localparam logic [9:0]  TOK_11   = 10'h2AB;
    localparam logic [7:0]  RUN_MAX  = 8'(TOKEN_RUN);
    localparam logic [7:0]  RUN_HIT  = 8'(TOKEN_RUN - 1);
    localparam logic [15:0] WCNT_END = 16'(SEARCH_WIN - 1);
    localparam logic [7:0]  WAIT_END = 8'(SLIP_WAIT - 1);
    localparam logic [23:0] LCNT_END = 24'(LOSS_WIN - 1);

    typedef enum logic [1:0] {
        StSearch,
        StSlip,
        StWait,
        StLocked
    } state_e;

    state_e      state;
    logic [9:0]  w1;
    logic        tok1;
    logic [1:0]  tok_ctl;
    logic [7:0]  d;
    logic [7:0]  dec;
    logic [7:0]  run;
    logic        hit;
    logic [15:0] wcnt;
    logic [7:0]  wait_cnt;
    logic [23:0] lcnt;

    // Stage 1: capture the raw word.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            w1 <= 10'd0;
        end else begin
            w1 <= din;
        end
    end

    // Control-token recognition on the stage-1 word.
    always_comb begin
        tok1    = 1'b1;
        tok_ctl = 2'b00;
        case (w1)
            TOK_00:  tok_ctl = 2'b00;
            TOK_01:  tok_ctl = 2'b01;
            TOK_10:  tok_ctl = 2'b10;
            TOK_11:  tok_ctl = 2'b11;
            default: tok1 = 1'b0;
        endcase
    end

    // Data decode: undo optional inversion (bit 9), then XOR/XNOR chain (bit 8 selects).
    always_comb begin
        d      = w1[9] ? ~w1[7:0] : w1[7:0];
        dec    = 8'd0;
        dec[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = w1[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    // Stage 2: registered outputs; the field not being updated keeps its last value.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            data <= 8'd0;
            ctl  <= 2'b00;
            de   <= 1'b0;
        end else if (tok1) begin
            ctl <= tok_ctl;
            de  <= 1'b0;
        end else begin
            data <= dec;
            de   <= 1'b1;
        end
    end

    // Token run length. Saturating at TOKEN_RUN means a long run yields a single hit.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 8'd0;
        end else if (!tok1 || state == StSlip || state == StWait) begin
            run <= 8'd0;
        end else if (run != RUN_MAX) begin
            run <= run + 8'd1;
        end
    end

    assign hit = tok1 && (run == RUN_HIT);

    // Alignment state machine with registered locked/bitslip/slip_count.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StSearch;
            wcnt       <= 16'd0;
            wait_cnt   <= 8'd0;
            lcnt       <= 24'd0;
            locked     <= 1'b0;
            bitslip    <= 1'b0;
            slip_count <= 4'd0;
        end else begin
            bitslip <= 1'b0;
            unique case (state)
                StSearch: begin
                    wcnt <= wcnt + 16'd1;
                    // A completed run takes priority over window expiry.
                    if (hit) begin
                        state  <= StLocked;
                        locked <= 1'b1;
                        lcnt   <= 24'd0;
                    end else if (wcnt == WCNT_END) begin
                        state      <= StSlip;
                        bitslip    <= 1'b1;
                        slip_count <= (slip_count == 4'd9) ? 4'd0 : slip_count + 4'd1;
                    end
                end
                StSlip: begin
                    state    <= StWait;
                    wait_cnt <= 8'd0;
                end
                StWait: begin
                    if (wait_cnt == WAIT_END) begin
                        state <= StSearch;
                        wcnt  <= 16'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                StLocked: begin
                    if (hit) begin
                        lcnt <= 24'd0;
                    end else if (lcnt == LCNT_END) begin
                        // Lost lock: search again from the current slip position.
                        state  <= StSearch;
                        locked <= 1'b0;
                        wcnt   <= 16'd0;
                    end else begin
                        lcnt <= lcnt + 24'd1;
                    end
                end
                default: state <= StSearch;
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_word_align.sv
// tb_tmds_word_align: directed testbench for tmds_word_align.
// The DUT runs with TOKEN_RUN=8, SEARCH_WIN=64, SLIP_WAIT=4, LOSS_WIN=256.
// Edge numbers (e) count pclk rising edges after reset release. Outputs are sampled on the
// falling edge after edge e.

module tb_tmds_word_align;

    logic       pclk    = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] din     = 10'd0;
    logic [7:0] data;
    logic [1:0] ctl;
    logic       de;
    logic       locked;
    logic       bitslip;
    logic [3:0] slip_count;

    int vec  = 0;
    int miss = 0;
    int cyc  = 0;
    int base = 0;
    int npulse = 0;
    int pulse_cyc [16];
    int k = 0;
    bit model_en = 1'b0;
    int seen;
    int chk_at;

    tmds_word_align #(
        .TOKEN_RUN  (8),
        .SEARCH_WIN (64),
        .SLIP_WAIT  (4),
        .LOSS_WIN   (256)
    ) dut (
        .pclk       (pclk),
        .reset_n    (reset_n),
        .din        (din),
        .data       (data),
        .ctl        (ctl),
        .de         (de),
        .locked     (locked),
        .bitslip    (bitslip),
        .slip_count (slip_count)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge. Each sampled bitslip cycle is logged and, when the
    // channel model is enabled, moves the deserializer phase by one bit.
    task automatic tick();
        @(negedge pclk);
        if (bitslip === 1'b1) begin
            if (npulse < 16) pulse_cyc[npulse] = cyc;
            npulse++;
            if (model_en) k = (k == 0) ? 9 : k - 1;
        end
    endtask

    task automatic do_reset(input logic [9:0] first);
        @(negedge pclk);
        reset_n = 1'b0;
        din     = 10'd0;
        @(negedge pclk);
        reset_n  = 1'b1;
        din      = first;
        base     = cyc;
        npulse   = 0;
        model_en = 1'b0;
    endtask

    // Transmitted word n of the acquisition stream: 16 blanking tokens, then 16 pixel words.
    function automatic logic [9:0] acq_word(input int n);
        return ((n % 32) < 16) ? 10'h354 : 10'h1FF;
    endfunction

    // Word seen by a deserializer whose boundary is kk bits late.
    function automatic logic [9:0] stream_word(input int n, input int kk);
        logic [19:0] pair;
        pair = {acq_word(n + 1), acq_word(n)};
        pair = pair >> kk;
        return pair[9:0];
    endfunction

    initial begin
        // Reset values, with a non-zero din present during reset.
        reset_n = 1'b0;
        din     = 10'h1FF;
        repeat (3) @(negedge pclk);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_ctl", 32'(ctl), 32'h0);
        chk("rst_de", 32'(de), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_bitslip", 32'(bitslip), 32'h0);
        chk("rst_slip_count", 32'(slip_count), 32'h0);

        // Decode, two-cycle latency.
        reset_n = 1'b1;
        din     = 10'h100;
        tick(); din = 10'h1FF;
        tick(); din = 10'h2FF;
        chk("dec_100_data", 32'(data), 32'h00);
        chk("dec_100_de", 32'(de), 32'h1);
        tick(); din = 10'h0AB;
        chk("dec_1ff_data", 32'(data), 32'h01);
        tick(); din = 10'h100;
        chk("dec_2ff_data", 32'(data), 32'hFE);
        chk("dec_2ff_de", 32'(de), 32'h1);
        tick();
        chk("dec_0ab_ctl", 32'(ctl), 32'h1);
        chk("dec_0ab_de", 32'(de), 32'h0);
        chk("dec_0ab_data_hold", 32'(data), 32'hFE);

        // Aligned lock on edge 9, then loss of lock 256 edges later with no slip.
        do_reset(10'h354);
        for (int e = 1; e <= 300; e++) begin
            tick();
            din = (e < 12) ? 10'h354 : 10'h1FF;
            if (e == 8) chk("lock_e8", 32'(locked), 32'h0);
            if (e == 9) begin
                chk("lock_e9", 32'(locked), 32'h1);
                chk("lock_tok_de", 32'(de), 32'h0);
            end
            if (e == 14) begin
                chk("lock_pix_de", 32'(de), 32'h1);
                chk("lock_pix_data", 32'(data), 32'h01);
            end
            if (e == 264) chk("loss_e264", 32'(locked), 32'h1);
            if (e == 265) chk("loss_e265", 32'(locked), 32'h0);
            if (e == 300) begin
                chk("loss_no_slip", 32'(npulse), 32'd0);
                chk("loss_slip_count", 32'(slip_count), 32'h0);
            end
        end

        // Hit and window expiry in the same cycle (tokens on edges 56..70).
        do_reset(10'h1FF);
        for (int e = 1; e <= 80; e++) begin
            tick();
            din = (e >= 55 && e <= 69) ? 10'h354 : 10'h1FF;
            if (e == 63) chk("tie_e63_locked", 32'(locked), 32'h0);
            if (e == 64) begin
                chk("tie_e64_locked", 32'(locked), 32'h1);
                chk("tie_e64_bitslip", 32'(bitslip), 32'h0);
            end
            if (e == 80) chk("tie_no_slip", 32'(npulse), 32'd0);
        end

        // Misaligned acquisition: stream 3 bits late, one bit recovered per bitslip.
        do_reset(10'h000);
        k        = 3;
        model_en = 1'b1;
        din      = stream_word(0, k);
        for (int e = 1; e <= 300; e++) begin
            tick();
            din = stream_word(e, k);
        end
        chk("acq_pulses", 32'(npulse), 32'd3);
        chk("acq_first", 32'(pulse_cyc[0] - base), 32'd64);
        chk("acq_gap1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd69);
        chk("acq_gap2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd69);
        chk("acq_locked", 32'(locked), 32'h1);
        chk("acq_slip_count", 32'(slip_count), 32'd3);

        // Slip wrap: no tokens for 11 windows -> positions 1..9, 0, 1.
        do_reset(10'h1FF);
        seen   = 0;
        chk_at = -1;
        for (int e = 1; e <= 770; e++) begin
            tick();
            din = 10'h1FF;
            if (npulse != seen) begin
                seen   = npulse;
                chk_at = e + 2;
            end
            if (e == chk_at) chk("wrap_slip_count", 32'(slip_count), 32'(seen % 10));
        end
        chk("wrap_pulses", 32'(npulse), 32'd11);
        chk("wrap_locked", 32'(locked), 32'h0);

        // Loss of lock with only 7-token runs every 200 cycles.
        do_reset(10'h354);
        for (int e = 1; e <= 270; e++) begin
            tick();
            din = (e < 12 || (e >= 59 && e <= 65) || (e >= 259 && e <= 265)) ? 10'h354
                                                                             : 10'h1FF;
            if (e == 9)   chk("short_lock", 32'(locked), 32'h1);
            if (e == 264) chk("short_e264", 32'(locked), 32'h1);
            if (e == 265) chk("short_e265", 32'(locked), 32'h0);
            if (e == 270) chk("short_no_slip", 32'(npulse), 32'd0);
        end

        // Reset asserted during a bitslip pulse, then during WAIT.
        do_reset(10'h1FF);
        for (int e = 1; e <= 64; e++) begin
            tick();
            din = 10'h1FF;
        end
        chk("rpulse_bitslip_hi", 32'(bitslip), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rpulse_bitslip", 32'(bitslip), 32'h0);
        chk("rpulse_slip_count", 32'(slip_count), 32'h0);
        do_reset(10'h1FF);
        for (int e = 1; e <= 66; e++) begin
            tick();
            din = 10'h1FF;
            if (e == 64) chk("rwait_pre_count", 32'(slip_count), 32'd1);
        end
        reset_n = 1'b0;
        #1;
        chk("rwait_slip_count", 32'(slip_count), 32'h0);
        chk("rwait_locked", 32'(locked), 32'h0);
        do_reset(10'h1FF);
        for (int e = 1; e <= 64; e++) begin
            tick();
            din = 10'h1FF;
            if (e == 63) chk("rwait_restart_e63", 32'(bitslip), 32'h0);
            if (e == 64) begin
                chk("rwait_restart_e64", 32'(bitslip), 32'h1);
                chk("rwait_restart_count", 32'(slip_count), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/tmds_word_align.md
# tmds_word_align

Consumes the 10-bit parallel words from the 1:10 differential deserializer and finds the TMDS word boundary. It watches for runs of TMDS control tokens and issues bitslip requests until a run appears. It then decodes each word into 8-bit pixel data or a 2-bit control code with a data-enable flag. The block sits between the deserializer and the per-channel pixel pipeline, one instance per TMDS channel, all in the `pclk` domain.

## Interface
Parameters:
- `TOKEN_RUN`, default 8: consecutive control-token words that count as a valid blanking run (2..255).
- `SEARCH_WIN`, default 2048: cycles allowed per slip position before the next bitslip (16..65535).
- `SLIP_WAIT`, default 16: settle cycles after a bitslip before searching resumes (1..255).
- `LOSS_WIN`, default 1048576: cycles in LOCKED without a run before lock is dropped (2..2^24).

Ports:
- `pclk` in 1: pixel clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `din` in 10: deserialized word; `din[0]` is the first bit received on the wire.
- `data` out 8: decoded pixel byte.
- `ctl` out 2: decoded control code {C1,C0}.
- `de` out 1: 1 = `data` is valid pixel data; 0 = `ctl` is valid.
- `locked` out 1: word alignment is established.
- `bitslip` out 1: one-cycle request pulse. The parent crosses it to the `pclkx1p25` domain.
- `slip_count` out 4: current slip position, 0..9.

## Operation
- Stage 1: register `din` into `w1`. Set `tok1` = 1 when `w1` equals 0x354, 0x0AB, 0x154 or 0x2AB.
- Stage 2 decode, registered:
  - Token words: 0x354→ctl 00, 0x0AB→01, 0x154→10, 0x2AB→11. `de`=0 and `data` holds its last value.
  - Other words: `de`=1 and `ctl` holds its last value.
  - Data path: d = w1[9] ? ~w1[7:0] : w1[7:0]; data[0]=d[0].
  - data[i] = d[i]^d[i-1] when w1[8]=1, otherwise ~(d[i]^d[i-1]), for i=1..7.
- Run counter `run`, 8-bit:
  - Increments while `tok1`=1 and saturates at `TOKEN_RUN`.
  - Clears when `tok1`=0 and throughout SLIP and WAIT.
  - `hit` = `tok1` & (`run` == `TOKEN_RUN`-1), which is the cycle the run completes.
- State machine, reset state SEARCH:
  - SEARCH: window counter `wcnt` increments each cycle.
    - `hit` → LOCKED.
    - Otherwise, `wcnt` == `SEARCH_WIN`-1 → SLIP.
    - If both occur in the same cycle, `hit` wins.
  - SLIP, one cycle: `bitslip`=1; `slip_count` ← (`slip_count`==9) ? 0 : `slip_count`+1; go to WAIT.
  - WAIT: counter runs `SLIP_WAIT` cycles, then go to SEARCH with `wcnt`=0.
  - LOCKED: `locked`=1 and loss counter `lcnt` (24-bit) increments.
    - `hit` clears `lcnt`.
    - `lcnt` == `LOSS_WIN`-1 without `hit` → SEARCH, with `locked`=0 and `wcnt`=0. No slip is issued on exit.
- `slip_count` is never cleared except by reset.

## Timing
- Reset values: `data`=0, `ctl`=0, `de`=0, `locked`=0, `bitslip`=0, `slip_count`=0. Internally: `w1`=0, `run`=0, `wcnt`=0, `lcnt`=0, state SEARCH.
- `reset_n` assertion mid-operation returns everything to reset values immediately, including during a `bitslip` pulse.
- `din` to `data`/`ctl`/`de` latency is 2 cycles, fully pipelined, one word per cycle, no stalls.
- `locked` rises on the clock edge after `hit`: `TOKEN_RUN`+1 edges after the first token word is sampled on `din`.
- `bitslip` is high for exactly 1 cycle per SLIP. Consecutive pulses are at least `SLIP_WAIT`+`SEARCH_WIN`+1 cycles apart.
- `locked` falls exactly `LOSS_WIN` cycles after the last `hit`.
- A run longer than `TOKEN_RUN` produces a single `hit`. A new `hit` requires a non-token word first.

## Test plan
- Reset and decode:
  - Hold `reset_n`=0 → all outputs 0.
  - Release and drive 0x100, 0x1FF, 0x2FF → after 2 cycles `data` = 0x00, 0x01, 0xFE with `de`=1.
  - Drive 0x0AB → `ctl`=01, `de`=0.
- Aligned lock: after reset, drive 12 × 0x354 then pixel words → `locked`=1 on edge 9, `bitslip` never asserted, `slip_count`=0.
- Misaligned acquisition: with `SEARCH_WIN`=64 and `SLIP_WAIT`=4, feed a stream rotated 3 bit positions; a model applies one rotation per `bitslip` → exactly 3 pulses, each 69 cycles apart. Then `locked`=1 and `slip_count`=3.
- Slip wrap: a stream with no tokens for 11 search windows → 11 pulses and `slip_count` sequence 1..9, 0, 1. `locked` stays 0.
- Loss of lock: with `LOSS_WIN`=256, once locked feed only pixel words → `locked` falls 256 cycles after the last `hit`, with no `bitslip`.
  - Repeat with a 7-token run every 200 cycles → `locked` still drops, since 7 tokens is below `TOKEN_RUN`.
- Edge cases:
  - `hit` and window expiry in the same cycle → LOCKED, no `bitslip`.
  - `reset_n` pulsed low during WAIT → `slip_count`=0, SEARCH restarts.
